// File: rtl/utopia_rx_cell_assembler_pkg.sv
// Shared types and constants for the Utopia receive-side cell path.
package utopia_rx_cell_assembler_pkg;

    localparam int unsigned CELL_BYTES = 53;
    localparam int unsigned HEC_BYTE   = 4;
    localparam logic [7:0]  HEC_COSET  = 8'h55;
    localparam logic [7:0]  HEC_POLY   = 8'h07;

    // Mem[0] is the first byte on the wire and sits in the low byte of the word.
    typedef struct packed {
        logic [CELL_BYTES-1:0][7:0] Mem;
    } ATMCellType;

    typedef enum logic [2:0] {
        StIdle,
        StWaitSoc,
        StRecv,
        StCheck,
        StHold
    } rx_state_e;

endpackage

// File: rtl/utopia_rx_cell_assembler_hec_crc8.sv
// Combinational ATM header HEC: CRC-8 (x^8+x^2+x+1, init 0, MSB first) over the
// four header bytes, XORed with the coset. Shared with the transmit-side generator.
module atm_hec_crc8
    import utopia_rx_cell_assembler_pkg::*;
(
    input  logic [31:0] header_i,
    output logic [7:0]  hec_o
);

    logic [7:0] crc;
    logic       fb;

    // Bit-serial CRC unrolled over the 32 header bits, first byte's MSB first.
    always_comb begin
        crc = 8'h00;
        fb  = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            fb  = crc[7] ^ header_i[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? HEC_POLY : 8'h00);
        end
        hec_o = crc ^ HEC_COSET;
    end

endmodule

// File: rtl/utopia_rx_cell_assembler.sv
// Utopia Level-1 receive cell assembler: collects 53-byte cells from the PHY,
// checks the HEC, and hands good cells to the core through valid/ready.
module utopia_rx_cell_assembler
    import utopia_rx_cell_assembler_pkg::*;
#(
    parameter int unsigned IfWidth  = 8,
    parameter bit          HecCheck = 1'b1
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [IfWidth-1:0] data,
    input  logic               soc,
    input  logic               clav,
    output logic               en,
    output ATMCellType         ATMcell,
    output logic               valid,
    input  logic               ready,
    output logic               hec_err,
    output logic               frame_err,
    output logic [15:0]        cell_cnt,
    output logic [15:0]        err_cnt
);

    if (IfWidth != 8) begin : g_width_check
        $error("utopia_rx_cell_assembler: only IfWidth == 8 is supported");
    end

    localparam logic [5:0] LastIdx = 6'(CELL_BYTES - 1);

    rx_state_e  state_q, state_d;
    logic [5:0] idx_q, idx_d;
    ATMCellType cell_q, cell_d;
    logic       en_q, en_d;
    logic       valid_q, valid_d;
    logic       hec_err_q, hec_err_d;
    logic       frame_err_q, frame_err_d;
    logic [15:0] cell_cnt_q, cell_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;

    logic [31:0] header;
    logic [7:0]  hec_calc;
    logic        hec_ok;
    logic        accept;

    // Bytes count only when we enabled the PHY last cycle and it had data.
    assign accept = ~en_q & clav;

    assign header = {cell_q.Mem[0], cell_q.Mem[1], cell_q.Mem[2], cell_q.Mem[3]};

    atm_hec_crc8 u_hec (
        .header_i (header),
        .hec_o    (hec_calc)
    );

    assign hec_ok = (hec_calc == cell_q.Mem[HEC_BYTE]);

    // Next-state, buffer writes, error pulses and counters.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cell_d      = cell_q;
        valid_d     = valid_q;
        hec_err_d   = 1'b0;
        frame_err_d = 1'b0;
        cell_cnt_d  = cell_cnt_q;
        err_sum     = 17'd0;

        unique case (state_q)
            StIdle: begin
                state_d = StWaitSoc;
            end

            StWaitSoc: begin
                // Bytes without soc are dropped while hunting for a cell start.
                if (accept && soc) begin
                    cell_d.Mem[0] = data;
                    idx_d         = 6'd1;
                    state_d       = StRecv;
                end
            end

            StRecv: begin
                if (accept) begin
                    if (soc) begin
                        // A fresh start-of-cell abandons the partial cell.
                        frame_err_d   = 1'b1;
                        cell_d.Mem[0] = data;
                        idx_d         = 6'd1;
                    end else begin
                        cell_d.Mem[idx_q] = data;
                        if (idx_q == LastIdx) begin
                            idx_d   = 6'd0;
                            state_d = StCheck;
                        end else begin
                            idx_d = idx_q + 6'd1;
                        end
                    end
                end
            end

            StCheck: begin
                if (!HecCheck || hec_ok) begin
                    valid_d = 1'b1;
                    state_d = StHold;
                end else begin
                    hec_err_d = 1'b1;
                    state_d   = StWaitSoc;
                end
            end

            StHold: begin
                if (valid_q && ready) begin
                    valid_d    = 1'b0;
                    cell_cnt_d = (cell_cnt_q == 16'hFFFF) ? cell_cnt_q : cell_cnt_q + 16'd1;
                    state_d    = StWaitSoc;
                end
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // Both error kinds may land on one edge; add them together and clamp.
        err_sum   = {1'b0, err_cnt_q} + 17'(hec_err_d) + 17'(frame_err_d);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Enable the PHY only when the next cycle can take a byte into the buffer.
    always_comb begin
        en_d = ~(((state_d == StWaitSoc) || (state_d == StRecv)) && !valid_d && clav);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= 6'd0;
            cell_q      <= '0;
            en_q        <= 1'b1;
            valid_q     <= 1'b0;
            hec_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            cell_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cell_q      <= cell_d;
            en_q        <= en_d;
            valid_q     <= valid_d;
            hec_err_q   <= hec_err_d;
            frame_err_q <= frame_err_d;
            cell_cnt_q  <= cell_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign en        = en_q;
    assign ATMcell   = cell_q;
    assign valid     = valid_q;
    assign hec_err   = hec_err_q;
    assign frame_err = frame_err_q;
    assign cell_cnt  = cell_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule
